// File: rtl/phase_seq.sv
// phase_seq: multi-cycle instruction sequencer (IDLE/F/D/E/M/W) with one-hot phase completion pulses.
// Optional feature: define CPU_MEM_SKIP_EN to route non-memory instructions from E straight to W.

`ifndef PH_F
`define PH_F 0
`endif
`ifndef PH_D
`define PH_D 1
`endif
`ifndef PH_E
`define PH_E 2
`endif
`ifndef PH_M
`define PH_M 3
`endif
`ifndef PH_W
`define PH_W 4
`endif

module phase_seq (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               run,
   output logic               imem_req,
   input  logic               imem_ack,
   input  logic               mem_op,
   output logic               dmem_req,
   input  logic               dmem_ack,
   input  logic               halt_inst,
   output logic [`PH_W:`PH_F] phase,
   output logic [`PH_W:`PH_F] cur_ph,
   output logic               running,
   output logic [31:0]        retired
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_F    = 3'd1,
      ST_D    = 3'd2,
      ST_E    = 3'd3,
      ST_M    = 3'd4,
      ST_W    = 3'd5
   } state_t;

   state_t      state_reg, state_next;
   logic        mem_pend_reg, mem_pend_next;
   logic [31:0] retired_reg, retired_next;
   logic        adv;
   logic        imem_req_raw;
   logic        dmem_req_raw;

   function automatic state_t ph_to_state(input int idx);
      case (idx)
         `PH_F:   ph_to_state = ST_F;
         `PH_D:   ph_to_state = ST_D;
         `PH_E:   ph_to_state = ST_E;
         `PH_M:   ph_to_state = ST_M;
         `PH_W:   ph_to_state = ST_W;
         default: ph_to_state = ST_IDLE;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg    <= ST_IDLE;
         mem_pend_reg <= 1'b0;
         retired_reg  <= 32'd0;
      end else begin
         state_reg    <= state_next;
         mem_pend_reg <= mem_pend_next;
         retired_reg  <= retired_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      mem_pend_next = mem_pend_reg;
      retired_next  = retired_reg;
      adv           = 1'b0;
      imem_req_raw  = 1'b0;
      dmem_req_raw  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (run)
               state_next = ST_F;
         end
         ST_F: begin
            imem_req_raw = 1'b1;
            adv          = imem_ack;
            if (imem_ack)
               state_next = ST_D;
         end
         ST_D: begin
            adv        = 1'b1;
            state_next = ST_E;
         end
         ST_E: begin
            adv           = 1'b1;
            mem_pend_next = mem_op;
`ifdef CPU_MEM_SKIP_EN
            state_next    = mem_op ? ST_M : ST_W;
`else
            state_next    = ST_M;
`endif
         end
         ST_M: begin
            // Without a pending access M is a single pass-through cycle.
            if (mem_pend_reg) begin
               dmem_req_raw = 1'b1;
               adv          = dmem_ack;
            end else begin
               adv = 1'b1;
            end
            if (!mem_pend_reg || dmem_ack)
               state_next = ST_W;
         end
         ST_W: begin
            adv          = 1'b1;
            retired_next = retired_reg + 32'd1;
            // Halt takes priority over a still-asserted run.
            state_next   = (halt_inst || !run) ? ST_IDLE : ST_F;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = `PH_F; gi <= `PH_W; gi = gi + 1) begin : g_cur_ph
         assign cur_ph[gi] = (state_reg == ph_to_state(gi));
      end
   endgenerate

   // Reset masks the combinational outputs so an in-flight ack cannot leak a pulse.
   assign phase    = (n_rst && adv) ? cur_ph : '0;
   assign imem_req = n_rst & imem_req_raw;
   assign dmem_req = n_rst & dmem_req_raw;
   assign running  = (state_reg != ST_IDLE);
   assign retired  = retired_reg;

endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: directed, table-driven bench for phase_seq, with hand-written stall, halt,
// run-drop, reset and counter-wrap sequences. Follows CPU_MEM_SKIP_EN if defined.

`ifndef PH_F
`define PH_F 0
`endif
`ifndef PH_D
`define PH_D 1
`endif
`ifndef PH_E
`define PH_E 2
`endif
`ifndef PH_M
`define PH_M 3
`endif
`ifndef PH_W
`define PH_W 4
`endif

module tb_phase_seq;

   logic        clk = 1'b0;
   logic        n_rst, run, imem_ack, mem_op, dmem_ack, halt_inst;
   logic        imem_req, dmem_req, running;
   logic [4:0]  phase, cur_ph;
   logic [31:0] retired;

   int          n_checks = 0;
   int          n_pass   = 0;
   int unsigned pc_model = 0;
   int          imem_cnt = 0;
   int          dmem_cnt = 0;
   int          run_cnt  = 0;

   localparam logic [4:0] P_0 = 5'h00;
   localparam logic [4:0] P_F = 5'h01;
   localparam logic [4:0] P_D = 5'h02;
   localparam logic [4:0] P_E = 5'h04;
   localparam logic [4:0] P_M = 5'h08;
   localparam logic [4:0] P_W = 5'h10;

   always #5 clk = ~clk;

   phase_seq dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .run       (run),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .mem_op    (mem_op),
      .dmem_req  (dmem_req),
      .dmem_ack  (dmem_ack),
      .halt_inst (halt_inst),
      .phase     (phase),
      .cur_ph    (cur_ph),
      .running   (running),
      .retired   (retired)
   );

   typedef struct {
      logic        run;
      logic        imem_ack;
      logic        mem_op;
      logic        dmem_ack;
      logic        halt_inst;
      logic [4:0]  exp_phase;
      logic [4:0]  exp_cur;
      logic        exp_imem;
      logic        exp_dmem;
      logic        exp_running;
      logic [31:0] exp_retired;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic ia, input logic mo, input logic da,
                               input logic hi, input logic [4:0] ep, input logic [4:0] ec,
                               input logic ei, input logic ed, input logic er,
                               input logic [31:0] ert);
      vec_t v;
      v.run = r; v.imem_ack = ia; v.mem_op = mo; v.dmem_ack = da; v.halt_inst = hi;
      v.exp_phase = ep; v.exp_cur = ec; v.exp_imem = ei; v.exp_dmem = ed;
      v.exp_running = er; v.exp_retired = ert;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
      else
         n_pass++;
   endtask

   // Inputs are set at a falling edge by the caller; outputs are sampled 1ns later.
   task automatic step(input string nm, input logic [4:0] ep, input logic [4:0] ec,
                       input logic ei, input logic ed, input logic er, input logic [31:0] ert);
      #1;
      chk({nm, ".phase"},    32'(phase),    32'(ep));
      chk({nm, ".cur_ph"},   32'(cur_ph),   32'(ec));
      chk({nm, ".imem_req"}, 32'(imem_req), 32'(ei));
      chk({nm, ".dmem_req"}, 32'(dmem_req), 32'(ed));
      chk({nm, ".running"},  32'(running),  32'(er));
      chk({nm, ".retired"},  retired,       ert);
      if (phase[`PH_F] === 1'b1) pc_model += 4;
      if (imem_req === 1'b1) imem_cnt++;
      if (dmem_req === 1'b1) dmem_cnt++;
      if (running === 1'b1) run_cnt++;
      $display("%0t %s phase=%h cur_ph=%h imem_req=%b dmem_req=%b running=%b retired=%0d",
               $time, nm, phase, cur_ph, imem_req, dmem_req, running, retired);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned pc_start;
      int          cnt_base;
      int          exp_cycles;

      n_rst = 1'b0; run = 1'b0; imem_ack = 1'b0; mem_op = 1'b0; dmem_ack = 1'b0; halt_inst = 1'b0;

      // Main zero-wait table: one IDLE launch cycle, three instructions, then IDLE.
      vecs.push_back(mk(1, 1, 0, 1, 0, P_0, P_0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++) begin
         vecs.push_back(mk(1, 1, 0, 1, 0, P_F, P_F, 1, 0, 1, k));
         vecs.push_back(mk(1, 1, 0, 1, 0, P_D, P_D, 0, 0, 1, k));
         vecs.push_back(mk(1, 1, 0, 1, 0, P_E, P_E, 0, 0, 1, k));
`ifndef CPU_MEM_SKIP_EN
         vecs.push_back(mk(1, 1, 0, 1, 0, P_M, P_M, 0, 0, 1, k));
`endif
         vecs.push_back(mk((k == 2) ? 1'b0 : 1'b1, 1, 0, 1, 0, P_W, P_W, 0, 0, 1, k));
      end
      vecs.push_back(mk(0, 1, 0, 1, 0, P_0, P_0, 0, 0, 0, 3));
`ifdef CPU_MEM_SKIP_EN
      exp_cycles = 12;
`else
      exp_cycles = 15;
`endif

      // Reset
      @(negedge clk);
      #1;
      chk("in_reset.phase",    32'(phase),    32'(P_0));
      chk("in_reset.imem_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;
      step("reset", P_0, P_0, 0, 0, 0, 0);

      run_cnt = 0;
      foreach (vecs[i]) begin
         run       = vecs[i].run;
         imem_ack  = vecs[i].imem_ack;
         mem_op    = vecs[i].mem_op;
         dmem_ack  = vecs[i].dmem_ack;
         halt_inst = vecs[i].halt_inst;
         step($sformatf("vec%0d", i), vecs[i].exp_phase, vecs[i].exp_cur, vecs[i].exp_imem,
              vecs[i].exp_dmem, vecs[i].exp_running, vecs[i].exp_retired);
      end
      chk("main.busy_cycles", 32'(run_cnt), 32'(exp_cycles));

      // Fetch stall of 4 cycles followed by a data stall of 3 cycles, then halt in W.
      run = 1'b1; imem_ack = 1'b0; mem_op = 1'b0; dmem_ack = 1'b0; halt_inst = 1'b0;
      step("a_idle", P_0, P_0, 0, 0, 0, 3);
      pc_start = pc_model;
      cnt_base = imem_cnt;
      for (int i = 0; i < 4; i++)
         step($sformatf("a_fstall%0d", i), P_0, P_F, 1, 0, 1, 3);
      imem_ack = 1'b1;
      step("a_fack", P_F, P_F, 1, 0, 1, 3);
      chk("a.imem_req_cycles", 32'(imem_cnt - cnt_base), 32'd5);
      chk("a.pc_delta", pc_model - pc_start, 32'd4);
      imem_ack = 1'b0; dmem_ack = 1'b1;
      step("a_d", P_D, P_D, 0, 0, 1, 3);
      dmem_ack = 1'b0; mem_op = 1'b1;
      step("a_e", P_E, P_E, 0, 0, 1, 3);
      mem_op = 1'b0;
      cnt_base = dmem_cnt;
      for (int i = 0; i < 3; i++)
         step($sformatf("a_mstall%0d", i), P_0, P_M, 0, 1, 1, 3);
      dmem_ack = 1'b1;
      step("a_mack", P_M, P_M, 0, 1, 1, 3);
      chk("a.dmem_req_cycles", 32'(dmem_cnt - cnt_base), 32'd4);
      dmem_ack = 1'b0; halt_inst = 1'b1;
      step("a_w_halt", P_W, P_W, 0, 0, 1, 3);
      halt_inst = 1'b0;
      step("a_idle_halted", P_0, P_0, 0, 0, 0, 4);

      // run drops during D: the instruction still retires, then the core idles.
      imem_ack = 1'b1;
      step("b_f", P_F, P_F, 1, 0, 1, 4);
      run = 1'b0;
      step("b_d", P_D, P_D, 0, 0, 1, 4);
      step("b_e", P_E, P_E, 0, 0, 1, 4);
`ifndef CPU_MEM_SKIP_EN
      step("b_m", P_M, P_M, 0, 0, 1, 4);
`endif
      step("b_w", P_W, P_W, 0, 0, 1, 4);
      imem_ack = 1'b0;
      step("b_idle", P_0, P_0, 0, 0, 0, 5);
      step("b_idle2", P_0, P_0, 0, 0, 0, 5);

      // Reset asserted in M while dmem_ack is high.
      run = 1'b1; imem_ack = 1'b1;
      step("r_idle", P_0, P_0, 0, 0, 0, 5);
      run = 1'b0;
      step("r_f", P_F, P_F, 1, 0, 1, 5);
      imem_ack = 1'b0;
      step("r_d", P_D, P_D, 0, 0, 1, 5);
      mem_op = 1'b1;
      step("r_e", P_E, P_E, 0, 0, 1, 5);
      mem_op = 1'b0; n_rst = 1'b0; dmem_ack = 1'b1;
      #1;
      chk("r_m_rst.phase",    32'(phase),    32'(P_0));
      chk("r_m_rst.dmem_req", 32'(dmem_req), 32'd0);
      chk("r_m_rst.imem_req", 32'(imem_req), 32'd0);
      @(negedge clk);
      n_rst = 1'b1; dmem_ack = 1'b0;
      step("r_after", P_0, P_0, 0, 0, 0, 0);

      // Counter wrap: preload the retired counter to all-ones, then retire one instruction.
      force dut.retired_reg = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.retired_reg;
      run = 1'b1; imem_ack = 1'b1;
      step("w_idle", P_0, P_0, 0, 0, 0, 32'hFFFF_FFFF);
      run = 1'b0;
      step("w_f", P_F, P_F, 1, 0, 1, 32'hFFFF_FFFF);
      step("w_d", P_D, P_D, 0, 0, 1, 32'hFFFF_FFFF);
      step("w_e", P_E, P_E, 0, 0, 1, 32'hFFFF_FFFF);
`ifndef CPU_MEM_SKIP_EN
      step("w_m", P_M, P_M, 0, 0, 1, 32'hFFFF_FFFF);
`endif
      step("w_w", P_W, P_W, 0, 0, 1, 32'hFFFF_FFFF);
      imem_ack = 1'b0;
      step("w_wrapped", P_0, P_0, 0, 0, 0, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
